// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for a Y86-style core: walks F/D/E/M/W/PCUPD per
// instruction, selects the next PC and reports machine status.
module seq_ctrl #(
    parameter logic [63:0] PC_RESET = 64'd0,
    parameter logic [63:0] PC_LIMIT = 64'd127
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        halt,
    input  logic        cnd,
    input  logic        dmem_error,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] PC,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        writeback_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_STOP      = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fetch_q, decode_q, execute_q, memory_q, writeback_q, busy_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        case (state_q)
            // start is only honoured while not busy
            S_IDLE, S_STOP: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_RESET;
                    stat_d  = STAT_AOK;
                    cnt_d   = 32'd0;
                end
            end
            S_FETCH: begin
                if (pc_q >= PC_LIMIT) begin
                    state_d = S_STOP;
                    stat_d  = STAT_ADR;
                end else if (icode > 4'hB) begin
                    state_d = S_STOP;
                    stat_d  = STAT_INS;
                end else if (halt) begin
                    state_d = S_STOP;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (dmem_error) begin
                    state_d = S_STOP;
                    stat_d  = STAT_ADR;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                if (icode == 4'h8 || (icode == 4'h7 && cnd)) begin
                    pc_d = valC;
                end else if (icode == 4'h9) begin
                    pc_d = valM;
                end else begin
                    pc_d = valP;
                end
                cnt_d   = cnt_q + 32'd1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and busy are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            stat_q      <= STAT_AOK;
            cnt_q       <= 32'd0;
            fetch_q     <= 1'b0;
            decode_q    <= 1'b0;
            execute_q   <= 1'b0;
            memory_q    <= 1'b0;
            writeback_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stat_q      <= stat_d;
            cnt_q       <= cnt_d;
            fetch_q     <= (state_d == S_FETCH);
            decode_q    <= (state_d == S_DECODE);
            execute_q   <= (state_d == S_EXECUTE);
            memory_q    <= (state_d == S_MEMORY);
            writeback_q <= (state_d == S_WRITEBACK);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_STOP);
        end
    end

    assign PC           = pc_q;
    assign stat         = stat_q;
    assign instr_count  = cnt_q;
    assign fetch_en     = fetch_q;
    assign decode_en    = decode_q;
    assign execute_en   = execute_q;
    assign memory_en    = memory_q;
    assign writeback_en = writeback_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: instruction flow, PC selection, fault stops,
// restart and asynchronous reset.
module tb_seq_ctrl;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  icode;
    logic        halt;
    logic        cnd;
    logic        dmem_error;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic [63:0] PC;
    logic        fetch_en;
    logic        decode_en;
    logic        execute_en;
    logic        memory_en;
    logic        writeback_en;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] instr_count;
    logic [2:0]  dbg_state;

    int checks;
    int failures;
    logic [63:0] exp_q[$];

    seq_ctrl dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .icode       (icode),
        .halt        (halt),
        .cnd         (cnd),
        .dmem_error  (dmem_error),
        .valC        (valC),
        .valP        (valP),
        .valM        (valM),
        .PC          (PC),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .execute_en  (execute_en),
        .memory_en   (memory_en),
        .writeback_en(writeback_en),
        .stat        (stat),
        .busy        (busy),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [4:0] strb();
        return {fetch_en, decode_en, execute_en, memory_en, writeback_en};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered with the DUT in FETCH; leaves it in the next FETCH.
    task automatic run_instr(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                             input logic [63:0] vp, input logic [63:0] vm,
                             input logic [63:0] exp_pc, input logic [31:0] exp_cnt);
        icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
        check("strobe_f", 64'(strb()), 64'b10000);
        tick(); check("strobe_d", 64'(strb()), 64'b01000);
        tick(); check("strobe_e", 64'(strb()), 64'b00100);
        tick(); check("strobe_m", 64'(strb()), 64'b00010);
        tick(); check("strobe_w", 64'(strb()), 64'b00001);
        tick(); check("strobe_pcupd", 64'(strb()), 64'b00000);
        check("busy_pcupd", 64'(busy), 64'd1);
        tick(); check("strobe_next_f", 64'(strb()), 64'b10000);
        check("pc_after", PC, exp_pc);
        check("count_after", 64'(instr_count), 64'(exp_cnt));
    endtask

    initial begin
        checks = 0; failures = 0;
        resetn = 1'b0; start = 1'b0; icode = 4'h0; halt = 1'b0; cnd = 1'b0;
        dmem_error = 1'b0; valC = '0; valP = '0; valM = '0;
        #12;
        check("rst_pc", PC, 64'd0);
        check("rst_stat", 64'(stat), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        check("rst_strobes", 64'(strb()), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        check("idle_no_start", 64'(dbg_state), 64'd0);

        pulse_start();
        check("start_pc", PC, 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        check("start_stat", 64'(stat), 64'd1);

        // Sequential loop: PC 0 -> 1 -> 2 -> 3
        exp_q.push_back(64'd1); exp_q.push_back(64'd2); exp_q.push_back(64'd3);
        for (int i = 0; i < 3; i++) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            run_instr(4'h1, 1'b0, 64'd0, PC + 64'd1, 64'd0, e, 32'(i + 1));
        end
        check("loop_count", 64'(instr_count), 64'd3);

        run_instr(4'h7, 1'b1, 64'h40, 64'd5, 64'd0, 64'h40, 32'd4);
        run_instr(4'h7, 1'b0, 64'h80, 64'd9, 64'd0, 64'd9, 32'd5);
        run_instr(4'h8, 1'b0, 64'h20, 64'hA, 64'h30, 64'h20, 32'd6);
        run_instr(4'h9, 1'b0, 64'h50, 64'h21, 64'h0A, 64'h0A, 32'd7);
        run_instr(4'h1, 1'b0, 64'd0, 64'd5, 64'd0, 64'd5, 32'd8);

        // Halt at PC=5
        icode = 4'h0; halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_stat", 64'(stat), 64'd2);
        check("halt_pc", PC, 64'd5);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_strobes", 64'(strb()), 64'd0);
        tick(); tick();
        check("stop_hold_pc", PC, 64'd5);
        check("stop_hold_count", 64'(instr_count), 64'd8);
        check("stop_hold_stat", 64'(stat), 64'd2);

        pulse_start();
        check("restart_pc", PC, 64'd0);
        check("restart_stat", 64'(stat), 64'd1);
        check("restart_count", 64'(instr_count), 64'd0);

        // Invalid instruction
        icode = 4'hC;
        tick();
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_busy", 64'(busy), 64'd0);
        check("ins_pc", PC, 64'd0);

        // PC reaching the limit; also icode=C there: address check wins
        pulse_start();
        run_instr(4'h1, 1'b0, 64'd0, 64'd127, 64'd0, 64'd127, 32'd1);
        icode = 4'hC;
        tick();
        check("adr_limit_stat", 64'(stat), 64'd3);
        check("adr_limit_pc", PC, 64'd127);
        check("adr_limit_count", 64'(instr_count), 64'd1);

        // Data memory error in MEMORY
        pulse_start();
        icode = 4'h5; valP = 64'd10;
        tick(); tick(); tick();
        check("dmem_in_mem", 64'(strb()), 64'b00010);
        dmem_error = 1'b1;
        tick();
        dmem_error = 1'b0;
        check("dmem_stat", 64'(stat), 64'd3);
        check("dmem_no_wb", 64'(writeback_en), 64'd0);
        check("dmem_pc", PC, 64'd0);
        check("dmem_count", 64'(instr_count), 64'd0);

        // start while busy is ignored
        pulse_start();
        run_instr(4'h1, 1'b0, 64'd0, 64'd3, 64'd0, 64'd3, 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 64'(strb()), 64'b00100);
        check("busy_start_pc", PC, 64'd3);
        check("busy_start_count", 64'(instr_count), 64'd1);

        // Asynchronous reset during EXECUTE
        #2;
        resetn = 1'b0;
        #1;
        check("arst_pc", PC, 64'd0);
        check("arst_count", 64'(instr_count), 64'd0);
        check("arst_stat", 64'(stat), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_strobes", 64'(strb()), 64'd0);
        check("arst_state", 64'(dbg_state), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        pulse_start();
        check("post_rst_fetch", 64'(strb()), 64'b10000);
        check("post_rst_pc", PC, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
